// File: rtl/fft_pkg.sv
// Shared types and sizing for the FFT frame sequencer.
// Frame geometry, read latency and watchdog limit live here.
package fft_pkg;

    localparam int N       = 64;
    localparam int LOG2N   = 6;
    localparam int DW      = 16;
    localparam int RD_LAT  = 1;
    localparam int TIMEOUT = 4096;
    localparam int WDW     = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_LOAD,
        S_START,
        S_WAIT,
        S_UNLOAD
    } fft_seq_state_t;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft_result_reader.sv
// Walks the FFT result RAM bin by bin and presents each bin
// on a valid/ready port, honouring the RAM read latency.
module fft_result_reader
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2*DW-1:0]   fft_wd,
    input  logic              out_ready,
    output logic [LOG2N-1:0]  adr,
    output logic              out_valid,
    output logic [2*DW-1:0]   out_data,
    output logic [LOG2N-1:0]  out_idx,
    output logic              out_last,
    output logic              last_done
);

    localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);

    logic [LOG2N-1:0] bin;
    logic             pend;
    logic [3:0]       lat;
    cplx_t            data_q;
    logic             hs;

    assign hs        = out_valid & out_ready;
    assign last_done = hs & out_last;
    assign out_data  = data_q;

    // The next address goes out in the handshake cycle itself.
    always_comb begin
        adr = bin;
        if (start)
            adr = '0;
        else if (hs && !out_last)
            adr = bin + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin       <= '0;
            pend      <= 1'b0;
            lat       <= '0;
            data_q    <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (start) begin
            bin       <= '0;
            pend      <= 1'b1;
            lat       <= LAT_INIT;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (pend) begin
                if (lat == '0) begin
                    pend      <= 1'b0;
                    out_valid <= 1'b1;
                    data_q    <= cplx_t'(fft_wd);
                    out_idx   <= bin;
                    out_last  <= (bin == LOG2N'(N - 1));
                end else begin
                    lat <= lat - 1'b1;
                end
            end
            if (hs) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                if (!out_last) begin
                    bin  <= bin + 1'b1;
                    pend <= 1'b1;
                    lat  <= LAT_INIT;
                end else begin
                    bin <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frames audio samples into the 64-point FFT, starts it, and
// streams the resulting bins to a valid/ready consumer.
module fft_frame_sequencer
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clr_flags,
    input  logic              s_valid,
    input  logic [DW-1:0]     s_data,
    output logic              fft_load,
    output logic              fft_start,
    output logic [LOG2N-1:0]  fft_adr,
    output logic [2*DW-1:0]   fft_rd,
    input  logic              fft_done,
    input  logic [2*DW-1:0]   fft_wd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*DW-1:0]   out_data,
    output logic [LOG2N-1:0]  out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err,
    output logic [15:0]       frame_cnt
);

    fft_seq_state_t   state, state_nxt;
    logic [LOG2N-1:0] cnt;
    logic [WDW-1:0]   wdog;
    logic [LOG2N-1:0] rd_adr;
    logic             rd_last;
    logic             accept;
    logic             tmo;
    logic             drop;
    cplx_t            ld;

    assign accept = (state == S_LOAD) & s_valid & enable;
    assign tmo    = (state == S_WAIT) & ~fft_done
                  & (wdog == WDW'(TIMEOUT - 1));
    assign drop   = (state != S_LOAD) & s_valid & enable;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_LOAD;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_LOAD:
                if (accept && cnt == LOG2N'(N - 1))
                    state_nxt = S_START;
            S_START:
                state_nxt = S_WAIT;
            S_WAIT:
                if (fft_done)
                    state_nxt = S_UNLOAD;
                else if (tmo)
                    state_nxt = S_LOAD;
            S_UNLOAD:
                if (rd_last)
                    state_nxt = S_LOAD;
            default:
                state_nxt = S_LOAD;
        endcase
    end

    always_comb begin
        ld        = '0;
        ld.re     = s_data;
        fft_load  = accept;
        fft_start = (state == S_START);
        fft_rd    = accept ? ld : '0;
        fft_adr   = (state == S_LOAD) ? cnt : rd_adr;
        busy      = (state != S_LOAD);
    end

    // Sample count restarts whenever collection is interrupted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            wdog        <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            if (state != S_LOAD || !enable)
                cnt <= '0;
            else if (s_valid)
                cnt <= cnt + 1'b1;
            wdog <= (state == S_WAIT) ? wdog + 1'b1 : '0;
            if (drop)
                overrun <= 1'b1;
            else if (clr_flags)
                overrun <= 1'b0;
            if (tmo)
                timeout_err <= 1'b1;
            else if (clr_flags)
                timeout_err <= 1'b0;
            if (rd_last)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

    fft_result_reader u_reader (
        .clk       (clk),
        .reset     (reset),
        .start     ((state == S_WAIT) & fft_done),
        .fft_wd    (fft_wd),
        .out_ready (out_ready),
        .adr       (rd_adr),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .last_done (rd_last)
    );

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for the FFT frame sequencer with a simple
// latency-1 result RAM and delayed-done FFT model.
module tb_fft_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        clr_flags = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        fft_load;
    logic        fft_start;
    logic [5:0]  fft_adr;
    logic [31:0] fft_rd;
    logic        fft_done = 1'b0;
    logic [31:0] fft_wd = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [5:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        overrun;
    logic        timeout_err;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int dcnt = 0;
    bit done_en = 1'b1;

    fft_frame_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .clr_flags   (clr_flags),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .fft_load    (fft_load),
        .fft_start   (fft_start),
        .fft_adr     (fft_adr),
        .fft_rd      (fft_rd),
        .fft_done    (fft_done),
        .fft_wd      (fft_wd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wd_of(input logic [5:0] a);
        logic [15:0] re;
        logic [15:0] im;
        re = 16'h1000 + {10'd0, a} * 16'd3;
        im = 16'hF000 ^ {10'd0, a};
        return {re, im};
    endfunction

    // Result RAM: one cycle from address to data.
    always @(posedge clk) fft_wd <= wd_of(fft_adr);

    // FFT core: done 20 cycles after start, held until next start.
    always @(posedge clk) begin
        if (fft_start) begin
            start_cnt <= start_cnt + 1;
            fft_done  <= 1'b0;
            dcnt      <= done_en ? 20 : 0;
        end else if (dcnt > 1) begin
            dcnt <= dcnt - 1;
        end else if (dcnt == 1) begin
            dcnt     <= 0;
            fft_done <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Loads n back-to-back samples, expecting addresses from a0.
    task automatic load_frame(input int n, input int a0);
        bit bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            s_valid = 1'b1;
            s_data  = 16'(i + 7);
            #1;
            if (!(fft_load === 1'b1 && fft_adr === 6'(a0 + i)
                  && fft_rd === {16'(i + 7), 16'h0}))
                bad = 1'b1;
        end
        step();
        s_valid = 1'b0;
        chk("load_frame", {63'd0, bad}, 64'd0);
    endtask

    task automatic unload_frame(input int stall_bin, input int stall_len,
                                input int stop);
        int bin = 0;
        int stall = stall_len;
        int budget = 0;
        logic [37:0] saved = '0;
        while (bin < stop && budget < 2000) begin
            step();
            budget++;
            if (out_valid && int'(out_idx) == stall_bin && stall > 0) begin
                if (stall == stall_len)
                    saved = {out_idx, out_data};
                else
                    chk("stall_stable", {25'd0, out_valid, out_idx, out_data},
                        {25'd0, 1'b1, saved});
                out_ready = 1'b0;
                stall--;
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    chk("bin", {25'd0, out_last, out_idx, out_data},
                        {25'd0, bin == 63, 6'(bin), wd_of(6'(bin))});
                    bin++;
                end
            end
        end
        if (bin < stop)
            chk("unload_timeout", 64'(bin), 64'(stop));
        step();
    endtask

    typedef struct {
        logic [15:0] s_data;
        logic        exp_load;
        logic [5:0]  exp_adr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[64];

    initial begin
        int n;
        for (int i = 0; i < 64; i++)
            vecs[i] = '{16'(i), 1'b1, 6'(i), {16'(i), 16'h0}};

        // Reset state
        #12;
        chk("reset_outputs",
            {fft_load, fft_start, fft_adr, fft_rd, out_valid, out_last,
             busy, overrun, timeout_err, frame_cnt},
            64'd0);
        chk("reset_out_data", {26'd0, out_idx, out_data}, 64'd0);
        #11 reset = 1'b1;
        enable = 1'b1;

        // 1: table-driven sample loading, one sample every 4 cycles
        for (int i = 0; i < 64; i++) begin
            step();
            s_valid = 1'b1;
            s_data  = vecs[i].s_data;
            #1;
            chk("load_vec", {23'd0, fft_start, busy, fft_load, fft_adr, fft_rd},
                {23'd0, 1'b0, 1'b0, vecs[i].exp_load, vecs[i].exp_adr,
                 vecs[i].exp_rd});
            step();
            s_valid = 1'b0;
            if (i < 63)
                repeat (2) @(posedge clk);
        end
        chk("start_pulse", {61'd0, fft_start, fft_load, busy}, 64'b101);
        step();
        chk("start_one_cycle", {62'd0, fft_start, busy}, 64'b01);

        // 2: full unload, consumer always ready
        unload_frame(-1, 0, 64);
        chk("frame_cnt_1", 64'(frame_cnt), 64'd1);
        chk("idle_after_1", {62'd0, busy, out_valid}, 64'd0);
        chk("one_start", 64'(start_cnt), 64'd1);

        // 3: consumer stalls 5 cycles on bin 10
        load_frame(64, 0);
        unload_frame(10, 5, 64);
        chk("frame_cnt_2", 64'(frame_cnt), 64'd2);

        // 4: samples during WAIT are dropped and flagged
        load_frame(64, 0);
        step();
        step();
        s_valid = 1'b1;
        #1;
        chk("wait_no_load", {63'd0, fft_load}, 64'd0);
        step();
        s_valid = 1'b0;
        #1;
        chk("overrun_set", {63'd0, overrun}, 64'd1);
        step();
        s_valid   = 1'b1;
        clr_flags = 1'b1;
        step();
        s_valid   = 1'b0;
        clr_flags = 1'b0;
        #1;
        chk("overrun_set_wins", {63'd0, overrun}, 64'd1);
        step();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        #1;
        chk("overrun_cleared", {62'd0, overrun, busy}, 64'b01);
        unload_frame(-1, 0, 64);
        chk("frame_cnt_3", 64'(frame_cnt), 64'd3);

        // 5: FFT never finishes
        done_en = 1'b0;
        load_frame(64, 0);
        n = 0;
        while (busy && n < 5000) begin
            step();
            n++;
        end
        chk("timeout_cycles", 64'(n), 64'd4097);
        chk("timeout_flag", {62'd0, timeout_err, busy}, 64'b10);
        chk("frame_cnt_hold", 64'(frame_cnt), 64'd3);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        #1;
        chk("timeout_cleared", {63'd0, timeout_err}, 64'd0);
        done_en = 1'b1;

        // 6: enable drop discards the partial frame
        load_frame(30, 0);
        enable  = 1'b0;
        s_valid = 1'b1;
        #1;
        chk("disabled_no_load", {63'd0, fft_load}, 64'd0);
        step();
        step();
        s_valid = 1'b0;
        enable  = 1'b1;
        #1;
        chk("disabled_no_flag", {63'd0, overrun}, 64'd0);
        load_frame(64, 0);
        unload_frame(-1, 0, 8);
        chk("mid_unload", {62'd0, busy, out_valid}, 64'b10);
        chk("five_starts", 64'(start_cnt), 64'd5);
        #2 reset = 1'b0;
        #1;
        chk("async_reset",
            {fft_load, fft_start, fft_adr, fft_rd, out_valid, out_last,
             busy, overrun, timeout_err, frame_cnt},
            64'd0);
        chk("async_reset_data", {26'd0, out_idx, out_data}, 64'd0);
        #3 reset = 1'b1;
        step();
        s_valid = 1'b1;
        #1;
        chk("post_reset_adr0", {56'd0, fft_load, busy, fft_adr}, {56'd0, 2'b10, 6'd0});
        step();
        s_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

endmodule
